fp_to_int_seq: RTL and testbench
================================

# fp_to_int_seq

Multi-cycle converter from IEEE-754 single precision to signed 32-bit two's-complement integer. It is the consumer side of the fpa float datapath: fpa produces 32-bit floats, and this block turns them back into integers for the fixed-point side of the design. It uses a valid/ready handshake on both ends and an iterative shifter, so one conversion is in flight at a time.

## Interface
- SHIFT_STEP, default 1: bits shifted per SHIFT cycle. Legal values are 1, 2, 4 and 8.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  number_in is valid.
- in_ready  output  1  block can accept an input; high only in IDLE.
- number_in  input  32  IEEE-754 single, {sign, exp[7:0], mantis[22:0]}.
- out_valid  output  1  int_out and flags are valid.
- out_ready  input  1  downstream accepts the result.
- int_out  output  32  signed integer result.
- flags  output  3  [2] invalid, [1] overflow, [0] inexact.

## Operation
- States: IDLE, CLASSIFY, SHIFT, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture number_in and go to CLASSIFY.
- CLASSIFY: unpack sign, exp, mantis; hidden bit = (exp!=0); e = exp-127. Cases, in priority order:
  - exp=255, mantis!=0 (NaN): result 0x8000_0000, invalid=1, go to DONE.
  - exp=255, mantis=0 (±inf): result 0x7FFF_FFFF (+) or 0x8000_0000 (−), invalid=1, go to DONE.
  - exp=0 (±0 or denormal): result 0, inexact = (mantis!=0), go to DONE.
  - sign=1, exp=158, mantis=0 (exactly −2^31): result 0x8000_0000, no flags, go to DONE.
  - e>=31: saturate to 0x7FFF_FFFF (+) or 0x8000_0000 (−), overflow=1, go to DONE.
  - e<=−2: load W = 0 with sticky=1, go to ROUND.
  - e=−1: load W with 1.m at bit 31 (value 0.1m), go to ROUND.
  - 0<=e<=30: load W with hidden bit at bit 32 and mantissa at bits 31:9. cnt = e. Go to SHIFT if cnt!=0, otherwise ROUND.
- W is a 64-bit fixed-point register: bits 63:32 are the integer part I, bits 31:0 are the fraction F. A separate sticky bit holds fraction lost below W.
- SHIFT:
  - Each cycle: W <<= min(SHIFT_STEP, cnt); cnt -= the same amount.
  - When cnt reaches 0, go to ROUND.
- ROUND:
  - inexact = (F!=0) | sticky.
  - mag = I, truncating toward zero.
  - Apply sign (two's complement when sign=1), go to DONE.
  - Rounding never overflows: F=0 whenever e>=23.
- DONE:
  - out_valid=1; int_out and flags are held stable until out_ready=1.
  - Go to IDLE on the cycle after the handshake.
- −0.0 converts to 0 with no flags.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, int_out=0, flags=0. Reset asserted mid-operation aborts the conversion; no result is produced.
- Input accepted in cycle T (in_valid & in_ready). Output is first presented at:
  - Special or saturated inputs: out_valid in cycle T+2.
  - Normal inputs: out_valid in cycle T+3+n, with n = ceil(e/SHIFT_STEP) (n=0 when e<=0).
- in_ready=0 from T+1 until the cycle after the output handshake. Minimum issue interval is latency+1 cycles.
- out_valid never drops without a handshake. in_valid while busy is ignored and not captured.

## Configuration
- ROUND_NEAREST_EN:
  - Defined: ROUND uses round-to-nearest-even. mag = I+1 when F[31] & (F[30:0]!=0 | sticky | I[0]). For e<=−2 the result stays 0. inexact rule is unchanged.
  - Undefined: truncation toward zero, as specified above.

## Test plan
- Pi: 0x40490FDB, SHIFT_STEP=1 -> int_out=3, flags=3'b001, out_valid at T+4.
- Halves and sign: 0x3FC00000 (1.5) -> 1 (truncate) or 2 (ROUND_NEAREST_EN), flags=001. 0xC0200000 (−2.5) -> 0xFFFF_FFFE in both modes, flags=001.
- Largest shifts, SHIFT_STEP=1 vs 8:
  - 0x4EFFFFFF -> 0x7FFF_FF80, flags=000, out_valid at T+33 (SHIFT_STEP=1).
  - Same input with SHIFT_STEP=8 -> same result, out_valid at T+7.
- Boundary values:
  - 0xCF000000 -> 0x8000_0000, flags=000.
  - 0x4F000000 -> 0x7FFF_FFFF, flags=010.
  - 0x00000001 -> 0, flags=001.
  - 0x80000000 -> 0, flags=000.
- NaN with backpressure: 0x7FC00000 with out_ready held low 5 cycles -> 0x8000_0000, flags=100, out_valid from T+2. Outputs stay stable and in_ready=0 throughout. in_ready=1 the cycle after out_ready rises.
- Reset mid-SHIFT: 0x4E000000, rst_n pulsed low during SHIFT -> out_valid=0 and in_ready=1 immediately. The next input 0x3F800000 -> 1, flags=000.

Source files
------------

// File: rtl/fp_to_int_seq.sv
// Multi-cycle IEEE-754 single to signed int32 converter, valid/ready on both ends.
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.

module fp_to_int_seq #(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] number_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] int_out,
   output logic [2:0]  flags
);

   typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, ROUND, DONE} state_t;

   localparam logic [4:0] STEP = 5'(SHIFT_STEP);

   state_t      state_q, state_d;
   logic [31:0] num_q, num_d;
   logic [63:0] w_q, w_d;
   logic        sticky_q, sticky_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] int_q, int_d;
   logic [2:0]  flags_q, flags_d;

   logic        sign;
   logic [7:0]  exp_f;
   logic [22:0] mantis;
   logic [31:0] int_part;
   logic [31:0] frac;
   logic [31:0] mag;
   logic [4:0]  step;

   assign sign     = num_q[31];
   assign exp_f    = num_q[30:23];
   assign mantis   = num_q[22:0];
   assign int_part = w_q[63:32];
   assign frac     = w_q[31:0];
   assign step     = (cnt_q < STEP) ? cnt_q : STEP;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign int_out   = int_q;
   assign flags     = flags_q;

   // Magnitude of the result; rounding up cannot overflow because F is zero for large exponents.
   always_comb begin
      mag = int_part;
`ifdef ROUND_NEAREST_EN
      if (frac[31] && ((|frac[30:0]) || sticky_q || int_part[0]))
         mag = int_part + 32'd1;
`endif
   end

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      w_d      = w_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      int_d    = int_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               num_d   = number_in;
               state_d = CLASSIFY;
            end
         end
         CLASSIFY: begin
            sticky_d = 1'b0;
            if (exp_f == 8'hFF) begin
               int_d   = (mantis == '0 && !sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
               flags_d = 3'b100;
               state_d = DONE;
            end else if (exp_f == 8'h00) begin
               int_d   = '0;
               flags_d = {2'b00, |mantis};
               state_d = DONE;
            end else if (sign && exp_f == 8'd158 && mantis == '0) begin
               int_d   = 32'h8000_0000;
               flags_d = 3'b000;
               state_d = DONE;
            end else if (exp_f >= 8'd158) begin
               int_d   = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
               flags_d = 3'b010;
               state_d = DONE;
            end else if (exp_f <= 8'd125) begin
               w_d      = '0;
               sticky_d = 1'b1;
               state_d  = ROUND;
            end else if (exp_f == 8'd126) begin
               w_d     = {32'd0, 1'b1, mantis, 8'd0};
               state_d = ROUND;
            end else begin
               // Hidden bit sits at the integer LSB; shifting left by e aligns the binary point.
               w_d     = {31'd0, 1'b1, mantis, 9'd0};
               cnt_d   = exp_f[4:0] - 5'd31;
               state_d = (exp_f == 8'd127) ? ROUND : SHIFT;
            end
         end
         SHIFT: begin
            w_d   = w_q << step;
            cnt_d = cnt_q - step;
            if (cnt_q == step)
               state_d = ROUND;
         end
         ROUND: begin
            int_d   = sign ? (~mag + 32'd1) : mag;
            flags_d = {2'b00, (|frac) | sticky_q};
            state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         num_q    <= '0;
         w_q      <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         int_q    <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         num_q    <= num_d;
         w_q      <= w_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         int_q    <= int_d;
         flags_q  <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Self-checking bench for fp_to_int_seq: two instances (SHIFT_STEP 1 and 8) checked
// every cycle against an arithmetic reference model, plus directed literal cases.

module tb_fp_to_int_seq;

   logic        clk;
   logic        rst_n;
   logic [1:0]  in_valid_v;
   logic [1:0]  out_ready_v;
   logic [1:0]  in_ready_v;
   logic [1:0]  out_valid_v;
   logic [63:0] number_v;
   logic [63:0] int_v;
   logic [5:0]  flags_v;

   int cyc = 0;
   int errors;
   int checks;

   logic [31:0] exp_int   [2];
   logic [2:0]  exp_flags [2];
   int          exp_lat   [2];
   int          acc_cyc   [2];
   int          rel_cyc   [2];
   bit          busy      [2];

   fp_to_int_seq #(.SHIFT_STEP(1)) dut_step1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[0]),
      .in_ready  (in_ready_v[0]),
      .number_in (number_v[31:0]),
      .out_valid (out_valid_v[0]),
      .out_ready (out_ready_v[0]),
      .int_out   (int_v[31:0]),
      .flags     (flags_v[2:0])
   );

   fp_to_int_seq #(.SHIFT_STEP(8)) dut_step8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[1]),
      .in_ready  (in_ready_v[1]),
      .number_in (number_v[63:32]),
      .out_valid (out_valid_v[1]),
      .out_ready (out_ready_v[1]),
      .int_out   (int_v[63:32]),
      .flags     (flags_v[5:3])
   );

   // Free-running clock and a cycle counter used to measure latency.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Generic compare: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model computed from the real value: significand scaled by 2^(e-23).
   task automatic modelConvert(input logic [31:0] x, input int stp, output logic [31:0] r,
                               output logic [2:0] f, output int lat);
      logic        s;
      logic [22:0] m;
      int          ex;
      int          e;
      int          sh;
      longint      sig;
      longint      q;
      longint      rem;
`ifdef ROUND_NEAREST_EN
      longint      half;
`endif
      s   = x[31];
      m   = x[22:0];
      ex  = int'(x[30:23]);
      e   = ex - 127;
      lat = 2;
      f   = 3'b000;
      r   = 32'd0;
      if (ex == 255) begin
         f = 3'b100;
         r = (m == 0 && !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      end else if (ex == 0) begin
         f = {2'b00, m != 0};
      end else if (s && ex == 158 && m == 0) begin
         r = 32'h8000_0000;
      end else if (e >= 31) begin
         f = 3'b010;
         r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         sig = longint'({1'b1, m});
         if (e >= 23) begin
            q   = sig << (e - 23);
            rem = 0;
         end else if (e >= -1) begin
            sh  = 23 - e;
            q   = sig >> sh;
            rem = sig - (q << sh);
`ifdef ROUND_NEAREST_EN
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0]))
               q = q + 1;
`endif
         end else begin
            q   = 0;
            rem = 1;
         end
         f   = {2'b00, rem != 0};
         r   = s ? 32'(-q) : 32'(q);
         lat = 3 + ((e > 0) ? (e + stp - 1) / stp : 0);
      end
   endtask

   function automatic logic [31:0] randFloat();
      logic [7:0]  ex;
      logic [22:0] m;
      int          sel;
      sel = $urandom_range(0, 15);
      if (sel == 0)      ex = 8'hFF;
      else if (sel == 1) ex = 8'h00;
      else if (sel < 4)  ex = 8'($urandom_range(0, 255));
      else               ex = 8'($urandom_range(120, 160));
      m   = 23'($urandom());
      sel = $urandom_range(0, 7);
      if (sel == 0)      m = '0;
      else if (sel == 1) m = 23'(1) << $urandom_range(0, 22);
      return {1'($urandom_range(0, 1)), ex, m};
   endfunction

   // One transaction on a lane: issue, wait bounded for the result, hold off out_ready, handshake.
   task automatic applyStimulus(input int idx, input logic [31:0] num, input int hold,
                                output logic [31:0] got_int, output logic [2:0] got_flags,
                                output int got_lat);
      int          waited;
      logic [31:0] m_int;
      logic [2:0]  m_flags;
      int          m_lat;
      got_int   = '0;
      got_flags = '0;
      got_lat   = -1;
      waited    = 0;
      while (!in_ready_v[idx] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      modelConvert(num, (idx == 0) ? 1 : 8, m_int, m_flags, m_lat);
      exp_int[idx]   = m_int;
      exp_flags[idx] = m_flags;
      exp_lat[idx]   = m_lat;
      acc_cyc[idx]   = cyc;
      busy[idx]      = 1'b1;
      in_valid_v[idx]          = 1'b1;
      number_v[idx*32 +: 32]   = num;
      @(negedge clk);
      waited = 0;
      while (!out_valid_v[idx] && waited < 60) begin
         in_valid_v[idx]        = 1'($urandom_range(0, 1));
         number_v[idx*32 +: 32] = $urandom();
         @(negedge clk);
         waited++;
      end
      if (!out_valid_v[idx]) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout lane %0d: out_valid=0 required 1 for input 0x%08h", idx, num);
         busy[idx]       = 1'b0;
         in_valid_v[idx] = 1'b0;
         rst_n           = 1'b0;
         @(negedge clk);
         rst_n        = 1'b1;
         rel_cyc[idx] = cyc;
         return;
      end
      got_lat = cyc - acc_cyc[idx];
      repeat (hold) @(negedge clk);
      got_int          = int_v[idx*32 +: 32];
      got_flags        = flags_v[idx*3 +: 3];
      in_valid_v[idx]  = 1'b0;
      out_ready_v[idx] = 1'b1;
      busy[idx]        = 1'b0;
      rel_cyc[idx]     = cyc;
      @(negedge clk);
      out_ready_v[idx] = 1'b0;
      checkOutput($sformatf("in_ready_after_hs[%0d]", idx), {31'd0, in_ready_v[idx]}, 32'd1);
      checkOutput($sformatf("out_valid_after_hs[%0d]", idx), {31'd0, out_valid_v[idx]}, 32'd0);
   endtask

   task automatic runDirected(input string name, input int idx, input logic [31:0] num, input int hold,
                              input logic [31:0] want_int, input logic [2:0] want_flags, input int want_lat);
      logic [31:0] gi;
      logic [2:0]  gf;
      int          gl;
      applyStimulus(idx, num, hold, gi, gf, gl);
      checkOutput({name, "_int"}, gi, want_int);
      checkOutput({name, "_flags"}, {29'd0, gf}, {29'd0, want_flags});
      checkOutput({name, "_latency"}, 32'(gl), 32'(want_lat));
   endtask

   // Per-cycle compare against the model for whichever lane has a conversion in flight.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            if (busy[i] && cyc > acc_cyc[i]) begin
               checkOutput($sformatf("in_ready_busy[%0d]", i), {31'd0, in_ready_v[i]}, 32'd0);
               if (cyc >= acc_cyc[i] + exp_lat[i]) begin
                  checkOutput($sformatf("out_valid[%0d]", i), {31'd0, out_valid_v[i]}, 32'd1);
                  checkOutput($sformatf("int_out[%0d]", i), int_v[i*32 +: 32], exp_int[i]);
                  checkOutput($sformatf("flags[%0d]", i), {29'd0, flags_v[i*3 +: 3]}, {29'd0, exp_flags[i]});
               end else begin
                  checkOutput($sformatf("out_valid_early[%0d]", i), {31'd0, out_valid_v[i]}, 32'd0);
               end
            end else if (!busy[i] && cyc > rel_cyc[i]) begin
               checkOutput($sformatf("in_ready_idle[%0d]", i), {31'd0, in_ready_v[i]}, 32'd1);
               checkOutput($sformatf("out_valid_idle[%0d]", i), {31'd0, out_valid_v[i]}, 32'd0);
            end
         end
      end
   end

   // Main sequence: reset, model pins, directed plan, reset abort, randomized traffic.
   initial begin
      logic [31:0] r;
      logic [2:0]  f;
      int          l;
      logic [31:0] gi;
      logic [2:0]  gf;
      int          gl;
      errors      = 0;
      checks      = 0;
      rst_n       = 1'b0;
      in_valid_v  = '0;
      out_ready_v = '0;
      number_v    = '0;
      for (int i = 0; i < 2; i++) begin
         busy[i]    = 1'b0;
         acc_cyc[i] = 0;
         rel_cyc[i] = 0;
         exp_lat[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("reset_in_ready[%0d]", i), {31'd0, in_ready_v[i]}, 32'd1);
         checkOutput($sformatf("reset_out_valid[%0d]", i), {31'd0, out_valid_v[i]}, 32'd0);
         checkOutput($sformatf("reset_int_out[%0d]", i), int_v[i*32 +: 32], 32'd0);
         checkOutput($sformatf("reset_flags[%0d]", i), {29'd0, flags_v[i*3 +: 3]}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      modelConvert(32'h40490FDB, 1, r, f, l);
      checkOutput("model_pi_int", r, 32'd3);
      checkOutput("model_pi_lat", 32'(l), 32'd4);
      modelConvert(32'hC0200000, 1, r, f, l);
      checkOutput("model_m2p5_int", r, 32'hFFFF_FFFE);
      checkOutput("model_m2p5_flags", {29'd0, f}, 32'd1);
      modelConvert(32'h4EFFFFFF, 8, r, f, l);
      checkOutput("model_big_int", r, 32'h7FFF_FF80);
      checkOutput("model_big_lat8", 32'(l), 32'd7);

      runDirected("pi", 0, 32'h40490FDB, 0, 32'd3, 3'b001, 4);
`ifdef ROUND_NEAREST_EN
      runDirected("one_half", 0, 32'h3FC00000, 1, 32'd2, 3'b001, 3);
`else
      runDirected("one_half", 0, 32'h3FC00000, 1, 32'd1, 3'b001, 3);
`endif
      runDirected("minus_2p5", 0, 32'hC0200000, 0, 32'hFFFF_FFFE, 3'b001, 4);
      runDirected("big_step1", 0, 32'h4EFFFFFF, 0, 32'h7FFF_FF80, 3'b000, 33);
      runDirected("big_step8", 1, 32'h4EFFFFFF, 2, 32'h7FFF_FF80, 3'b000, 7);
      runDirected("min_int", 0, 32'hCF000000, 0, 32'h8000_0000, 3'b000, 2);
      runDirected("pos_2p31", 0, 32'h4F000000, 0, 32'h7FFF_FFFF, 3'b010, 2);
      runDirected("denormal", 0, 32'h00000001, 0, 32'd0, 3'b001, 2);
      runDirected("neg_zero", 1, 32'h80000000, 0, 32'd0, 3'b000, 2);
      runDirected("nan_bp", 0, 32'h7FC00000, 5, 32'h8000_0000, 3'b100, 2);

      // Abort a long conversion in SHIFT with an asynchronous reset.
      modelConvert(32'h4E000000, 1, r, f, l);
      exp_int[0]    = r;
      exp_flags[0]  = f;
      exp_lat[0]    = l;
      acc_cyc[0]    = cyc;
      busy[0]       = 1'b1;
      in_valid_v[0] = 1'b1;
      number_v[31:0] = 32'h4E000000;
      @(negedge clk);
      in_valid_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      busy[0] = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkOutput("abort_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
      checkOutput("abort_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
      @(negedge clk);
      rst_n      = 1'b1;
      rel_cyc[0] = cyc;
      @(negedge clk);
      runDirected("after_abort", 0, 32'h3F800000, 0, 32'd1, 3'b000, 3);

      for (int k = 0; k < 150; k++) begin
         applyStimulus(0, randFloat(), $urandom_range(0, 3), gi, gf, gl);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1, randFloat(), $urandom_range(0, 3), gi, gf, gl);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
